// File: rtl/loop_filter_pi_gear.sv
// ADPLL proportional-integral loop filter with two-gear (ACQ/TRACK) bandwidth switching.
// Two-stage pipeline: gain multiply, then saturating integrate, sum, round and clamp.
module loop_filter_pi_gear #(
    parameter int ERROR_WIDTH   = 5,
    parameter int GAIN_WIDTH    = 7,
    parameter int ACC_WIDTH     = 16,
    parameter int FRAC_BITS     = 4,
    parameter int DCO_CC_WIDTH  = 5,
    parameter int GEAR_SHIFT    = 2,
    parameter int LOCK_THRESH   = 1,
    parameter int LOCK_COUNT    = 16,
    parameter int UNLOCK_THRESH = 4
) (
    input  logic                           gen_clk_i,
    input  logic                           reset_i,
    input  logic signed [ERROR_WIDTH-1:0]  error_i,
    input  logic                           error_valid_i,
    input  logic        [GAIN_WIDTH-1:0]   kp_i,
    input  logic        [GAIN_WIDTH-1:0]   ki_i,
    input  logic                           gain_load_i,
    input  logic                           freeze_i,
    input  logic                           int_clear_i,
    output logic signed [DCO_CC_WIDTH-1:0] dco_cc_o,
    output logic                           dco_cc_valid_o,
    output logic                           gear_o,
    output logic                           locked_o
);

    localparam int PROD_WIDTH = ERROR_WIDTH + GAIN_WIDTH + 1;
    localparam int CNT_WIDTH  = $clog2(LOCK_COUNT + 1);

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH:0]   HALF_LSB = (ACC_WIDTH+1)'(2 ** (FRAC_BITS-1));
    localparam logic signed [ACC_WIDTH:0]   DCO_MAX_W = (ACC_WIDTH+1)'(2 ** (DCO_CC_WIDTH-1) - 1);
    localparam logic signed [ACC_WIDTH:0]   DCO_MIN_W = (ACC_WIDTH+1)'(-(2 ** (DCO_CC_WIDTH-1)));

    typedef enum logic {
        GEAR_ACQ   = 1'b0,
        GEAR_TRACK = 1'b1
    } gear_t;

    gear_t                         gear_q;
    logic [CNT_WIDTH-1:0]          lock_cnt_q;
    logic [GAIN_WIDTH-1:0]         kp_r, ki_r, kp_eff, ki_eff;
    logic signed [PROD_WIDTH-1:0]  err_pw, kp_pw, ki_pw;
    logic signed [PROD_WIDTH-1:0]  p_r, i_r;
    logic                          s1_valid_q;
    logic                          accept;
    logic signed [ERROR_WIDTH:0]   err_ext;
    logic [ERROR_WIDTH:0]          err_abs;
    logic                          in_lock, lose_lock;

    logic signed [ACC_WIDTH-1:0]   int_q, int_base, int_next, sum;
    logic signed [ACC_WIDTH:0]     int_wide, sum_wide, rnd, shifted;
    logic signed [DCO_CC_WIDTH-1:0] dco_next;

    function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [ACC_WIDTH:0] x);
        if (x[ACC_WIDTH] != x[ACC_WIDTH-1])
            return x[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        return x[ACC_WIDTH-1:0];
    endfunction

    always_comb begin
        accept  = error_valid_i & ~freeze_i;
        kp_eff  = (gear_q == GEAR_TRACK) ? (kp_r >> GEAR_SHIFT) : kp_r;
        ki_eff  = (gear_q == GEAR_TRACK) ? (ki_r >> GEAR_SHIFT) : ki_r;
        err_pw  = $signed({{(PROD_WIDTH-ERROR_WIDTH){error_i[ERROR_WIDTH-1]}}, error_i});
        kp_pw   = $signed({{(PROD_WIDTH-GAIN_WIDTH){1'b0}}, kp_eff});
        ki_pw   = $signed({{(PROD_WIDTH-GAIN_WIDTH){1'b0}}, ki_eff});
        // One extra bit so the most-negative error has a representable magnitude.
        err_ext = $signed({error_i[ERROR_WIDTH-1], error_i});
        err_abs = err_ext[ERROR_WIDTH] ? $unsigned(-err_ext) : $unsigned(err_ext);
        in_lock   = err_abs <= (ERROR_WIDTH+1)'(LOCK_THRESH);
        lose_lock = err_abs >  (ERROR_WIDTH+1)'(UNLOCK_THRESH);
    end

    always_ff @(posedge gen_clk_i) begin
        if (reset_i) begin
            kp_r <= '0;
            ki_r <= '0;
        end else if (gain_load_i) begin
            kp_r <= kp_i;
            ki_r <= ki_i;
        end
    end

    always_ff @(posedge gen_clk_i) begin
        if (reset_i) begin
            s1_valid_q <= 1'b0;
            p_r        <= '0;
            i_r        <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                p_r <= err_pw * kp_pw;
                i_r <= err_pw * ki_pw;
            end
        end
    end

    always_ff @(posedge gen_clk_i) begin
        if (reset_i) begin
            gear_q     <= GEAR_ACQ;
            lock_cnt_q <= '0;
            gear_o     <= 1'b0;
            locked_o   <= 1'b0;
        end else if (accept) begin
            case (gear_q)
                GEAR_ACQ: begin
                    if (!in_lock) begin
                        lock_cnt_q <= '0;
                    end else if (lock_cnt_q == CNT_WIDTH'(LOCK_COUNT - 1)) begin
                        gear_q     <= GEAR_TRACK;
                        lock_cnt_q <= '0;
                        gear_o     <= 1'b1;
                        locked_o   <= 1'b1;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + CNT_WIDTH'(1);
                    end
                end
                GEAR_TRACK: begin
                    if (lose_lock) begin
                        gear_q     <= GEAR_ACQ;
                        lock_cnt_q <= '0;
                        gear_o     <= 1'b0;
                        locked_o   <= 1'b0;
                    end
                end
                default: begin
                    gear_q     <= GEAR_ACQ;
                    lock_cnt_q <= '0;
                    gear_o     <= 1'b0;
                    locked_o   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        int_base = int_clear_i ? '0 : int_q;
        int_wide = $signed({int_base[ACC_WIDTH-1], int_base})
                 + $signed({{(ACC_WIDTH+1-PROD_WIDTH){i_r[PROD_WIDTH-1]}}, i_r});
        int_next = sat_acc(int_wide);
        sum_wide = $signed({int_next[ACC_WIDTH-1], int_next})
                 + $signed({{(ACC_WIDTH+1-PROD_WIDTH){p_r[PROD_WIDTH-1]}}, p_r});
        sum      = sat_acc(sum_wide);
        rnd      = $signed({sum[ACC_WIDTH-1], sum}) + HALF_LSB;
        shifted  = rnd >>> FRAC_BITS;
        if (shifted > DCO_MAX_W)
            dco_next = DCO_MAX_W[DCO_CC_WIDTH-1:0];
        else if (shifted < DCO_MIN_W)
            dco_next = DCO_MIN_W[DCO_CC_WIDTH-1:0];
        else
            dco_next = shifted[DCO_CC_WIDTH-1:0];
    end

    // A clear beats a concurrent stage-2 write; that stage-2 output already used int=0.
    always_ff @(posedge gen_clk_i) begin
        if (reset_i) begin
            int_q          <= '0;
            dco_cc_o       <= '0;
            dco_cc_valid_o <= 1'b0;
        end else begin
            dco_cc_valid_o <= s1_valid_q;
            if (s1_valid_q)
                dco_cc_o <= dco_next;
            if (int_clear_i)
                int_q <= '0;
            else if (s1_valid_q)
                int_q <= int_next;
        end
    end

endmodule

// File: tb/tb_loop_filter_pi_gear.sv
// Self-checking bench for loop_filter_pi_gear: hand-computed vector table plus a
// behavioural reference model feeding a scoreboard of expected output codes.
module tb_loop_filter_pi_gear;

    logic              gen_clk_i = 1'b0;
    logic              reset_i = 1'b0;
    logic signed [4:0] error_i = '0;
    logic              error_valid_i = 1'b0;
    logic [6:0]        kp_i = '0;
    logic [6:0]        ki_i = '0;
    logic              gain_load_i = 1'b0;
    logic              freeze_i = 1'b0;
    logic              int_clear_i = 1'b0;
    logic signed [4:0] dco_cc_o;
    logic              dco_cc_valid_o;
    logic              gear_o;
    logic              locked_o;

    loop_filter_pi_gear #(
        .ERROR_WIDTH(5), .GAIN_WIDTH(7), .ACC_WIDTH(16), .FRAC_BITS(4),
        .DCO_CC_WIDTH(5), .GEAR_SHIFT(2), .LOCK_THRESH(1), .LOCK_COUNT(16),
        .UNLOCK_THRESH(4)
    ) dut (
        .gen_clk_i(gen_clk_i), .reset_i(reset_i), .error_i(error_i),
        .error_valid_i(error_valid_i), .kp_i(kp_i), .ki_i(ki_i),
        .gain_load_i(gain_load_i), .freeze_i(freeze_i), .int_clear_i(int_clear_i),
        .dco_cc_o(dco_cc_o), .dco_cc_valid_o(dco_cc_valid_o),
        .gear_o(gear_o), .locked_o(locked_o)
    );

    always #5 gen_clk_i = ~gen_clk_i;

    int total = 0;
    int bad = 0;
    int exp_q[$];

    int m_kp, m_ki, m_gear, m_cnt, m_int, m_dco, m_p, m_i;
    bit m_pend;

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic int clamp(input int x, input int lo, input int hi);
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

    always @(negedge gen_clk_i) begin
        if (dco_cc_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("pulse_code", int'(dco_cc_o), e);
            end
        end
    end

    task automatic model_reset();
        m_kp = 0; m_ki = 0; m_gear = 0; m_cnt = 0; m_int = 0; m_dco = 0;
        m_p = 0; m_i = 0; m_pend = 0;
    endtask

    // One clock: drive inputs, advance the reference model, then check held outputs.
    task automatic step(input int e, input bit v, input bit frz, input bit gl,
                        input int kp, input int ki, input bit clr, input bit rst);
        int in_v, s, a, kpe, kie;
        reset_i = rst; error_i = 5'(e); error_valid_i = v; freeze_i = frz;
        gain_load_i = gl; kp_i = 7'(kp); ki_i = 7'(ki); int_clear_i = clr;
        if (rst) begin
            model_reset();
        end else begin
            if (m_pend) begin
                in_v  = clamp((clr ? 0 : m_int) + m_i, -32768, 32767);
                s     = clamp(m_p + in_v, -32768, 32767);
                m_dco = clamp((s + 8) >>> 4, -16, 15);
                exp_q.push_back(m_dco);
                m_int = clr ? 0 : in_v;
            end else if (clr) begin
                m_int = 0;
            end
            if (v && !frz) begin
                kpe = m_gear ? (m_kp >> 2) : m_kp;
                kie = m_gear ? (m_ki >> 2) : m_ki;
                m_p = e * kpe;
                m_i = e * kie;
                m_pend = 1;
                a = (e < 0) ? -e : e;
                if (m_gear == 0) begin
                    if (a <= 1) begin
                        if (m_cnt == 15) begin m_gear = 1; m_cnt = 0; end
                        else m_cnt++;
                    end else m_cnt = 0;
                end else if (a > 4) begin
                    m_gear = 0; m_cnt = 0;
                end
            end else begin
                m_pend = 0;
            end
            if (gl) begin m_kp = kp; m_ki = ki; end
        end
        @(posedge gen_clk_i);
        #1;
        chk("dco_hold", int'(dco_cc_o), m_dco);
        chk("gear", int'(gear_o), m_gear);
        chk("locked", int'(locked_o), m_gear);
        reset_i = 1'b0; error_valid_i = 1'b0; gain_load_i = 1'b0;
        int_clear_i = 1'b0; freeze_i = 1'b0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic sample(input int e);
        step(e, 1, 0, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        int e; bit v; bit gl; int kp; int ki; int exp_dco; int exp_gear;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{e: 0,  v: 0, gl: 1, kp: 16, ki: 1, exp_dco: 0,  exp_gear: 0};
        tbl[1] = '{e: 2,  v: 1, gl: 0, kp: 0,  ki: 0, exp_dco: 0,  exp_gear: 0};
        tbl[2] = '{e: 0,  v: 0, gl: 0, kp: 0,  ki: 0, exp_dco: 2,  exp_gear: 0};
        tbl[3] = '{e: -3, v: 1, gl: 0, kp: 0,  ki: 0, exp_dco: 2,  exp_gear: 0};
        tbl[4] = '{e: 0,  v: 0, gl: 0, kp: 0,  ki: 0, exp_dco: -3, exp_gear: 0};
        tbl[5] = '{e: 15, v: 1, gl: 0, kp: 0,  ki: 0, exp_dco: -3, exp_gear: 0};
        tbl[6] = '{e: 0,  v: 0, gl: 0, kp: 0,  ki: 0, exp_dco: 15, exp_gear: 0};

        model_reset();
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_dco", int'(dco_cc_o), 0);
        chk("rst_valid", int'(dco_cc_valid_o), 0);
        chk("rst_gear", int'(gear_o), 0);

        for (int k = 0; k < 7; k++) begin
            step(tbl[k].e, tbl[k].v, 0, tbl[k].gl, tbl[k].kp, tbl[k].ki, 0, 0);
            chk("tbl_dco", int'(dco_cc_o), tbl[k].exp_dco);
            chk("tbl_gear", int'(gear_o), tbl[k].exp_gear);
        end

        // Integrator and output saturation in both directions.
        step(0, 0, 0, 1, 0, 127, 0, 0);
        for (int k = 0; k < 20; k++) sample(15);
        idle();
        chk("sat_pos", int'(dco_cc_o), 15);
        for (int k = 0; k < 40; k++) sample(-16);
        idle();
        chk("sat_neg", int'(dco_cc_o), -16);

        // Lock acquisition, reduced TRACK gain, loss of lock.
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 16, 1, 0, 0);
        for (int k = 0; k < 15; k++) sample(0);
        chk("gear_before_lock", int'(gear_o), 0);
        sample(0);
        chk("gear_lock", int'(gear_o), 1);
        sample(3);
        idle();
        chk("track_kp", int'(dco_cc_o), 1);
        sample(5);
        chk("gear_unlock", int'(gear_o), 0);
        sample(0);
        idle();
        chk("int_kept", int'(dco_cc_o), 0);

        // An out-of-lock sample restarts the count.
        sample(3);
        for (int k = 0; k < 15; k++) sample(0);
        sample(2);
        chk("gear_after_break", int'(gear_o), 0);
        for (int k = 0; k < 15; k++) sample(0);
        chk("gear_15_of_16", int'(gear_o), 0);
        sample(0);
        chk("gear_relock", int'(gear_o), 1);

        // Freeze: valid samples ignored, state held, then resume.
        step(0, 0, 0, 1, 16, 8, 0, 0);
        for (int k = 0; k < 3; k++) sample(4);
        for (int k = 0; k < 10; k++) step(15, 1, 1, 0, 0, 0, 0, 0);
        chk("freeze_gear", int'(gear_o), 1);
        sample(1);
        idle();

        // Gain load alongside a sample, integrator clear, reset mid-stream.
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 16, 16, 0, 0);
        step(1, 1, 0, 1, 64, 0, 0, 0);
        idle();
        chk("gl_old_gains", int'(dco_cc_o), 2);
        sample(1);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        chk("clr_out", int'(dco_cc_o), 4);
        sample(0);
        idle();
        chk("clr_int", int'(dco_cc_o), 0);
        sample(5);
        sample(5);
        chk("pre_rst_dco", int'(dco_cc_o), 15);
        step(5, 1, 0, 0, 0, 0, 0, 1);
        chk("midrst_dco", int'(dco_cc_o), 0);
        chk("midrst_valid", int'(dco_cc_valid_o), 0);
        chk("midrst_locked", int'(locked_o), 0);
        idle();
        idle();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/loop_filter_pi_gear.md
Name: loop_filter_pi_gear

Overview:
- Next-generation ADPLL proportional-integral loop filter.
- Sits between the phase detector (signed error) and the DCO control-code input.
- Adds over the previous filter: sample-valid pipelining, runtime gain load, saturating integrator and output, round-to-nearest truncation, freeze and integrator-clear controls.
- Adds automatic two-gear bandwidth switching: acquisition gains until lock is detected, then tracking gains; falls back to acquisition on loss of lock.

Parameters:
- ERROR_WIDTH, 5, phase-error width (signed).
- GAIN_WIDTH, 7, kp/ki width (unsigned).
- ACC_WIDTH, 16, integrator and sum width (signed); must be >= ERROR_WIDTH+GAIN_WIDTH+1.
- FRAC_BITS, 4, fractional LSBs dropped when forming the DCO code; must be >= 1.
- DCO_CC_WIDTH, 5, DCO control-code width (signed).
- GEAR_SHIFT, 2, right shift applied to kp and ki in the TRACK gear.
- LOCK_THRESH, 1, |error| <= this counts as an in-lock sample.
- LOCK_COUNT, 16, consecutive in-lock samples needed to enter TRACK.
- UNLOCK_THRESH, 4, |error| > this in TRACK returns the filter to ACQ.

Ports:
- gen_clk_i, in, 1, filter clock.
- reset_i, in, 1, reset; synchronous, active-high.
- error_i, in, ERROR_WIDTH, signed phase error.
- error_valid_i, in, 1, error_i is sampled on this cycle.
- kp_i, in, GAIN_WIDTH, acquisition proportional gain, unsigned.
- ki_i, in, GAIN_WIDTH, acquisition integral gain, unsigned.
- gain_load_i, in, 1, pulse: latch kp_i/ki_i.
- freeze_i, in, 1, hold the integrator, output and lock counter.
- int_clear_i, in, 1, pulse: zero the integrator.
- dco_cc_o, out, DCO_CC_WIDTH, signed DCO control code.
- dco_cc_valid_o, out, 1, one-cycle strobe: dco_cc_o updated.
- gear_o, out, 1, 0 = ACQ, 1 = TRACK.
- locked_o, out, 1, equals gear_o; kept as a separate port for the lock-status consumer.

Behaviour:
- Reset (synchronous, active-high), clears all state:
  - dco_cc_o=0, dco_cc_valid_o=0, gear_o=0, locked_o=0.
  - Integrator 0, lock counter 0, gain registers 0, pipeline valids 0.
  - Reset asserted mid-pipeline discards any in-flight sample.
- Gains:
  - Gain registers load on gain_load_i.
  - A sample accepted in the same cycle as gain_load_i uses the old gains.
  - Effective gains: ACQ uses kp_r and ki_r; TRACK uses kp_r>>GEAR_SHIFT and ki_r>>GEAR_SHIFT (logical shift).
- Stage 1, on error_valid_i & !freeze_i:
  - Register p_r = error_i*kp_eff and i_r = error_i*ki_eff.
  - Gains are zero-extended, so both products are signed and ERROR_WIDTH+GAIN_WIDTH+1 bits wide.
  - Register the lock-detect decision. With freeze_i high, error_valid_i is ignored entirely.
- Stage 2, one cycle after stage 1:
  - int_next = sat_ACC(int + i_r).
  - sum = sat_ACC(sign-extended p_r + int_next).
  - code = sum + 2^(FRAC_BITS-1), then arithmetic shift right by FRAC_BITS (round half up).
  - Register int <= int_next and dco_cc_o <= sat_DCO(code); pulse dco_cc_valid_o for one cycle.
- Latency: error_valid_i accepted at edge N gives dco_cc_valid_o=1 and the new dco_cc_o after edge N+1. Throughput is one sample per clock.
- Saturation:
  - sat_ACC clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - sat_DCO clamps to [-2^(DCO_CC_WIDTH-1), 2^(DCO_CC_WIDTH-1)-1].
  - The integrator never wraps.
- int_clear_i:
  - Forces int to 0 at the next edge and has priority over a stage-2 update in the same cycle.
  - The stage-2 output in that cycle is computed with int treated as 0.
  - It does not change dco_cc_o unless a stage-2 sample is present in that cycle.
- Gear FSM (sample-driven; updates only on accepted samples):
  - ACQ: |e| <= LOCK_THRESH increments the counter, otherwise the counter clears. When the counter reaches LOCK_COUNT, go to TRACK and clear the counter.
  - TRACK: |e| > UNLOCK_THRESH goes to ACQ with the counter cleared; otherwise stay in TRACK.
  - |e| of the most-negative error value is treated as 2^(ERROR_WIDTH-1).
  - The gear change takes effect for the sample following the one that caused it.
  - Integrator state is preserved across a gear change (bumpless).
- freeze_i: dco_cc_o, int, counter and gear hold. A sample already in stage 1 still completes stage 2.

Test Plan:
- Reset, then load kp=16, ki=1; one sample e=+2 -> after 2 edges dco_cc_valid_o pulses once, int=2, dco_cc_o=2 ((32+2+8)>>4).
- kp=0, ki=127, e=+15 on every cycle for 20 samples -> int clamps at 32767 (sample 18) and never wraps; dco_cc_o clamps at +15. Then e=-16 sustained -> dco_cc_o reaches -16.
- e=0 for 16 samples -> gear_o=1 after sample 16. Next sample uses kp=4 (from 16). Then e=+5 -> gear_o=0, counter 0, int unchanged.
- 15 samples e=0, then e=+2, then 16 samples e=0 -> gear_o rises only after the last sample (counter cleared by e=+2).
- freeze_i=1 for 10 valid samples -> no dco_cc_valid_o pulses; int and gear unchanged. Release -> the next sample resumes from the held state.
- gain_load_i with a sample in the same cycle -> old gains used. int_clear_i in the same cycle as stage 2 -> int=0. reset_i mid-stream -> all outputs 0 at the next edge, no valid pulse.
